// File: rtl/bsg_manycore_accel_store_sequencer_pkg.sv
// Shared types and constants for the accelerator store sequencer.
package bsg_manycore_accel_store_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StFence,
    StDone
  } state_e;

  localparam int unsigned OpWidth   = 2;
  localparam int unsigned OpExWidth = 4;

  // Remote store opcode and all-bytes write mask.
  localparam logic [OpWidth-1:0]   OpRemoteStore = 2'b01;
  localparam logic [OpExWidth-1:0] OpExAllBytes  = 4'b1111;

  // Packet layout, MSB first: addr, op, op_ex, data, src_y, src_x, y, x.
  function automatic int unsigned packet_width(input int unsigned addr_w,
                                               input int unsigned data_w,
                                               input int unsigned x_w,
                                               input int unsigned y_w);
    return addr_w + OpWidth + OpExWidth + data_w + 2 * (x_w + y_w);
  endfunction

endpackage

// File: rtl/bsg_manycore_accel_store_sequencer_if.sv
// Link between the sequencer and the endpoint out port.
interface bsg_manycore_accel_store_sequencer_if #(
  parameter int unsigned packet_width_p = 1,
  parameter int unsigned credit_width_p = 3
);
  logic [packet_width_p-1:0] packet;
  logic                      v;
  logic                      ready;
  logic [credit_width_p-1:0] credits;

  modport master (output packet, v, input ready, credits);
  modport slave  (input packet, v, output ready, credits);
endinterface

// File: rtl/bsg_manycore_accel_store_sequencer_dff.sv
// Enabled register with synchronous clear; holds per-command fields.
module bsg_manycore_accel_store_sequencer_dff #(
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;

  // Capture on enable, clear on reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_manycore_accel_store_sequencer.sv
// Issues a burst of remote write packets, one per streamed data word, then
// fences on returned credits before reporting done.
module bsg_manycore_accel_store_sequencer
  import bsg_manycore_accel_store_sequencer_pkg::*;
#(
  parameter int unsigned x_cord_width_p    = 4,
  parameter int unsigned y_cord_width_p    = 4,
  parameter int unsigned data_width_p      = 32,
  parameter int unsigned addr_width_p      = 16,
  parameter int unsigned count_width_p     = 16,
  parameter int unsigned max_out_credits_p = 4,
  localparam int unsigned credit_width_lp  = $clog2(max_out_credits_p + 1),
  localparam int unsigned packet_width_lp  =
    packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic                      cmd_v_i,
  output logic                      cmd_ready_o,
  input  logic [addr_width_p-1:0]   cmd_addr_i,
  input  logic [x_cord_width_p-1:0] cmd_x_i,
  input  logic [y_cord_width_p-1:0] cmd_y_i,
  input  logic [count_width_p-1:0]  cmd_count_i,
  input  logic [addr_width_p-1:0]   cmd_stride_i,

  input  logic                      data_v_i,
  input  logic [data_width_p-1:0]   data_i,
  output logic                      data_yumi_o,

  bsg_manycore_accel_store_sequencer_if.master out,

  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,

  output logic                      done_v_o,
  input  logic                      done_yumi_i
);

  localparam int unsigned cmd_width_lp = addr_width_p + y_cord_width_p + x_cord_width_p;
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
  localparam logic [count_width_p-1:0]   one_lp         = count_width_p'(1);

  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    logic [OpWidth-1:0]        op;
    logic [OpExWidth-1:0]      op_ex;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] src_y;
    logic [x_cord_width_p-1:0] src_x;
    logic [y_cord_width_p-1:0] y;
    logic [x_cord_width_p-1:0] x;
  } packet_s;

  state_e                     state_q;
  logic                       cmd_ready_q;
  logic                       done_v_q;
  logic [addr_width_p-1:0]    addr_q;
  logic [count_width_p-1:0]   remaining_q;
  logic [addr_width_p-1:0]    stride_r;
  logic [y_cord_width_p-1:0]  dest_y_r;
  logic [x_cord_width_p-1:0]  dest_x_r;
  logic                       cmd_accept;
  logic                       fire;
  packet_s                    pkt;
  logic [packet_width_lp-1:0] packet;

  assign cmd_accept = cmd_v_i & cmd_ready_q;

  // Stride and destination only change on command accept.
  bsg_manycore_accel_store_sequencer_dff #(
    .width_p(cmd_width_lp)
  ) cmd_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (cmd_accept),
    .data_i ({cmd_stride_i, cmd_y_i, cmd_x_i}),
    .data_o ({stride_r, dest_y_r, dest_x_r})
  );

  // Valid is independent of ready so the endpoint sees a stable offer.
  assign out.v       = (state_q == StSend) & data_v_i & (out.credits != '0);
  assign fire        = out.v & out.ready;
  assign data_yumi_o = fire;

  // Packet is assembled combinationally from the latched command and live data.
  always_comb begin
    pkt       = '0;
    pkt.addr  = addr_q;
    pkt.op    = OpRemoteStore;
    pkt.op_ex = OpExAllBytes;
    pkt.data  = data_i;
    pkt.src_y = my_y_i;
    pkt.src_x = my_x_i;
    pkt.y     = dest_y_r;
    pkt.x     = dest_x_r;
  end

  assign packet     = pkt;
  assign out.packet = packet;

  // Sequencer FSM: address/count stepping and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      done_v_q    <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_accept) begin
            addr_q      <= cmd_addr_i;
            remaining_q <= cmd_count_i;
            cmd_ready_q <= 1'b0;
            // An empty burst still has to wait for outstanding stores.
            state_q     <= (cmd_count_i != '0) ? StSend : StFence;
          end
        end
        StSend: begin
          if (fire) begin
            addr_q      <= addr_q + stride_r;
            remaining_q <= remaining_q - one_lp;
            if (remaining_q == one_lp) begin
              state_q <= StFence;
            end
          end
        end
        StFence: begin
          if (out.credits == max_credits_lp) begin
            state_q  <= StDone;
            done_v_q <= 1'b1;
          end
        end
        StDone: begin
          if (done_yumi_i) begin
            state_q     <= StIdle;
            done_v_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign done_v_o    = done_v_q;

endmodule
